// File: rtl/pipe_pkg.sv
// Shared types for the inter-stage pipeline buffers: occupancy state encoding,
// the NOP control word and the ID/EX payload layouts used to size DATA_W/CTRL_W.
package pipe_pkg;

    // Occupancy of one stage: encoding doubles as the o_count value.
    typedef enum logic [1:0] {
        PS_EMPTY = 2'd0,
        PS_BUSY  = 2'd1,
        PS_FULL  = 2'd2
    } pipe_state_e;

    // An all-zero control word never writes the register file or memory.
    localparam CTRL_NOP = '0;

    // ID/EX data payload: program counters, immediate and source operands.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] pc_plus4;
        logic [31:0] imm;
        logic [31:0] rs1_data;
        logic [31:0] rs2_data;
    } id_ex_data_t;

    // ID/EX control payload: every enable is active-high so zero is a bubble.
    typedef struct packed {
        logic       rd_wren;
        logic       mem_wren;
        logic       mem_rden;
        logic [1:0] wb_sel;
        logic [3:0] alu_op;
        logic       alu_src_imm;
        logic       branch;
        logic       jump;
        logic [2:0] funct3;
        logic       rsvd;
    } id_ex_ctrl_t;

    localparam int ID_EX_DATA_W = $bits(id_ex_data_t);
    localparam int ID_EX_CTRL_W = $bits(id_ex_ctrl_t);

endpackage

// File: rtl/pipe_entry_reg.sv
// One pipeline slot: data, control and valid held together.
// Clearing drops valid and zeroes control in the same edge; data is held.
module pipe_entry_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W = 160,
    parameter int CTRL_W = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_load,
    input  logic              i_clear,
    input  logic [DATA_W-1:0] i_data,
    input  logic [CTRL_W-1:0] i_ctrl,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data,
    output logic [CTRL_W-1:0] o_ctrl
);

    logic              r_valid;
    logic [DATA_W-1:0] r_data;
    logic [CTRL_W-1:0] r_ctrl;

    // Slot register: clear has priority over load so a squash always wins.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_valid <= 1'b0;
            r_data  <= {DATA_W{1'b0}};
            r_ctrl  <= {CTRL_W{1'b0}};
        end else if (i_clear) begin
            r_valid <= 1'b0;
            r_ctrl  <= CTRL_W'(CTRL_NOP);
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
            r_ctrl  <= i_ctrl;
        end else begin
            r_valid <= r_valid;
            r_data  <= r_data;
            r_ctrl  <= r_ctrl;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_ctrl  = r_ctrl;

endmodule

// File: rtl/pipe_stage_buf.sv
// Inter-stage pipeline register with valid/ready handshake, optional 2-entry
// skid buffer, hazard stall, flush and bubble insertion that zeroes control.
module pipe_stage_buf
    import pipe_pkg::*;
#(
    parameter int DATA_W  = 160,
    parameter int CTRL_W  = 16,
    parameter int SKID_EN = 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_flush,
    input  logic              i_stall,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    input  logic [CTRL_W-1:0] s_ctrl,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic [CTRL_W-1:0] m_ctrl,
    output logic [1:0]        o_count
);

    pipe_state_e       r_state;
    pipe_state_e       w_state_next;
    logic              r_s_ready;

    logic              w_in;
    logic              w_out;
    logic              w_main_load;
    logic              w_main_clear;
    logic [DATA_W-1:0] w_main_din;
    logic [CTRL_W-1:0] w_main_cin;
    logic              w_skid_load;
    logic              w_skid_clear;
    logic              w_skid_valid;
    logic [DATA_W-1:0] w_skid_data;
    logic [CTRL_W-1:0] w_skid_ctrl;

    // With the skid present s_ready comes from a flop; without it the single
    // slot can refill in the same cycle it drains, so ready follows m_ready.
    assign s_ready = (SKID_EN != 0) ? (r_s_ready & ~i_stall)
                                    : ((~m_valid | m_ready) & ~i_stall);

    // s_ready already carries the stall term.
    assign w_in  = s_valid & s_ready & ~i_flush;
    assign w_out = m_valid & m_ready & ~i_stall;

    // Occupancy straight from the state register.
    assign o_count[0] = (r_state == PS_BUSY);
    assign o_count[1] = (SKID_EN != 0) ? (r_state == PS_FULL) : 1'b0;

    // Next-state and slot load/clear decode: flush beats stall beats handshake.
    always_comb begin
        w_state_next = r_state;
        w_main_load  = 1'b0;
        w_main_clear = 1'b0;
        w_main_din   = s_data;
        w_main_cin   = s_ctrl;
        w_skid_load  = 1'b0;
        w_skid_clear = 1'b0;
        if (i_flush) begin
            w_state_next = PS_EMPTY;
            w_main_clear = 1'b1;
            w_skid_clear = 1'b1;
        end else if (i_stall) begin
            w_state_next = r_state;
        end else begin
            case (r_state)
                PS_EMPTY: begin
                    if (w_in) begin
                        w_main_load  = 1'b1;
                        w_state_next = PS_BUSY;
                    end else begin
                        w_state_next = PS_EMPTY;
                    end
                end
                PS_BUSY: begin
                    if (w_in && w_out) begin
                        w_main_load  = 1'b1;
                        w_state_next = PS_BUSY;
                    end else if (w_in && (SKID_EN != 0)) begin
                        w_skid_load  = 1'b1;
                        w_state_next = PS_FULL;
                    end else if (w_out) begin
                        // Drain with no refill: bubble, control zeroed.
                        w_main_clear = 1'b1;
                        w_state_next = PS_EMPTY;
                    end else begin
                        w_state_next = PS_BUSY;
                    end
                end
                PS_FULL: begin
                    if (w_out && w_skid_valid) begin
                        w_main_load  = 1'b1;
                        w_main_din   = w_skid_data;
                        w_main_cin   = w_skid_ctrl;
                        w_skid_clear = 1'b1;
                        w_state_next = PS_BUSY;
                    end else if (w_out) begin
                        // Skid unexpectedly empty: never copy stale contents.
                        w_main_clear = 1'b1;
                        w_state_next = PS_EMPTY;
                    end else begin
                        w_state_next = PS_FULL;
                    end
                end
                default: begin
                    w_main_clear = 1'b1;
                    w_skid_clear = 1'b1;
                    w_state_next = PS_EMPTY;
                end
            endcase
        end
    end

    // State register and registered upstream ready (ready unless about to be full).
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= PS_EMPTY;
            r_s_ready <= 1'b1;
        end else begin
            r_state   <= w_state_next;
            r_s_ready <= (w_state_next != PS_FULL);
        end
    end

    pipe_entry_reg #(
        .DATA_W (DATA_W),
        .CTRL_W (CTRL_W)
    ) u_main (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_load  (w_main_load),
        .i_clear (w_main_clear),
        .i_data  (w_main_din),
        .i_ctrl  (w_main_cin),
        .o_valid (m_valid),
        .o_data  (m_data),
        .o_ctrl  (m_ctrl)
    );

    generate
        if (SKID_EN != 0) begin : g_skid
            pipe_entry_reg #(
                .DATA_W (DATA_W),
                .CTRL_W (CTRL_W)
            ) u_skid (
                .i_clk   (i_clk),
                .i_rst   (i_rst),
                .i_load  (w_skid_load),
                .i_clear (w_skid_clear),
                .i_data  (s_data),
                .i_ctrl  (s_ctrl),
                .o_valid (w_skid_valid),
                .o_data  (w_skid_data),
                .o_ctrl  (w_skid_ctrl)
            );
        end else begin : g_no_skid
            assign w_skid_valid = 1'b0;
            assign w_skid_data  = {DATA_W{1'b0}};
            assign w_skid_ctrl  = {CTRL_W{1'b0}};
        end
    endgenerate

endmodule
